lsu_mem_master: RTL and testbench

- Load/store unit sitting between the execute stage and the single-port word-addressed data memory.
- Accepts byte-addressed RISC-V load/store requests over a valid/ready handshake and drives the memory's store-enable, word address, write data and access type.
- Sub-word loads are extracted and sign- or zero-extended from the full word read back.
- Sub-word stores are done as read-modify-write on whole words, so the memory only ever sees LW/SW accesses.
- Returns a one-cycle response carrying load data or a misalignment flag.

---
 rtl/lsu_mem_master.sv | 164 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit bridging the execute stage to a single-port word-addressed data memory.
// Sub-word stores are done as read-modify-write, so the memory only ever sees word accesses.
module lsu_mem_master #(
    parameter int unsigned MEM_AW  = 14,
    parameter logic [2:0]  TYPE_LW = 3'b010,
    parameter logic [2:0]  TYPE_SW = 3'b010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic              mem_is_store,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_type,
    input  logic [31:0]       mem_loaddata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    logic        fault;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Upper address bits wrap modulo memory size and are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    always_comb begin
        fault = 1'b0;
        if (req_is_store) begin
            unique case (req_funct3)
                3'b000:  fault = 1'b0;
                3'b001:  fault = req_addr[0];
                3'b010:  fault = (req_addr[1:0] != 2'b00);
                default: fault = 1'b1;
            endcase
        end else begin
            unique case (req_funct3)
                3'b000, 3'b100: fault = 1'b0;
                3'b001, 3'b101: fault = req_addr[0];
                3'b010:         fault = (req_addr[1:0] != 2'b00);
                default:        fault = 1'b1;
            endcase
        end
    end

    always_comb begin
        rd_byte = mem_loaddata[{lane_q, 3'b000} +: 8];
        rd_half = mem_loaddata[{lane_q[1], 4'b0000} +: 16];
        unique case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {24'h0, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_ext = {16'h0, rd_half};
            default: load_ext = mem_loaddata;
        endcase
    end

    always_comb begin
        merged = mem_loaddata;
        if (funct3_q[0]) begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'h0;
            resp_misaligned <= 1'b0;
            mem_is_store    <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= 32'h0;
            mem_type        <= TYPE_LW;
            is_store_q      <= 1'b0;
            funct3_q        <= 3'b000;
            lane_q          <= 2'b00;
            wdata_q         <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        if (fault) begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_rdata      <= 32'h0;
                            resp_misaligned <= 1'b1;
                        end else if (req_is_store && req_funct3 == 3'b010) begin
                            state        <= WRITE;
                            mem_addr     <= req_addr[MEM_AW+1:2];
                            mem_wdata    <= req_wdata;
                            mem_is_store <= 1'b1;
                            mem_type     <= TYPE_SW;
                        end else begin
                            state        <= READ;
                            mem_addr     <= req_addr[MEM_AW+1:2];
                            mem_is_store <= 1'b0;
                            mem_type     <= TYPE_LW;
                        end
                    end
                end
                READ: begin
                    if (is_store_q) begin
                        state        <= WRITE;
                        mem_wdata    <= merged;
                        mem_is_store <= 1'b1;
                        mem_type     <= TYPE_SW;
                    end else begin
                        state           <= RESP;
                        resp_valid      <= 1'b1;
                        resp_rdata      <= load_ext;
                        resp_misaligned <= 1'b0;
                    end
                end
                WRITE: begin
                    state           <= RESP;
                    mem_is_store    <= 1'b0;
                    mem_type        <= TYPE_LW;
                    resp_valid      <= 1'b1;
                    resp_rdata      <= 32'h0;
                    resp_misaligned <= 1'b0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    req_ready    <= 1'b1;
                    resp_valid   <= 1'b0;
                    mem_is_store <= 1'b0;
                    mem_type     <= TYPE_LW;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: a reference model predicts each response and write,
// and a negedge monitor checks them against the DUT and a behavioural memory.
module tb_lsu_mem_master;

    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_is_store = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_misaligned;
    logic          mem_is_store;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_type;
    logic [31:0]   mem_loaddata;

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] mm  [0:(1<<AW)-1];

    typedef struct {
        logic [31:0]   rdata;
        logic          mis;
        int            lat;
        int            acc;
        int            nwr;
        logic [AW-1:0] waddr;
        logic [31:0]   wdata;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   cur_wr = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    lsu_mem_master #(.MEM_AW(AW), .TYPE_LW(3'b010), .TYPE_SW(3'b010)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .mem_is_store(mem_is_store), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_loaddata(mem_loaddata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_loaddata = mem[mem_addr];
    always @(negedge clk) if (mem_is_store) mem[mem_addr] <= mem_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (q.size() == 0) begin
            check_eq("stray_write", {31'h0, mem_is_store}, 32'h0);
            check_eq("stray_resp", {31'h0, resp_valid}, 32'h0);
        end else if (cyc >= q[0].acc) begin
            check_eq("ready_busy", {31'h0, req_ready}, 32'h0);
            if (mem_is_store) begin
                cur_wr++;
                check_eq("wr_addr", {18'h0, mem_addr}, {18'h0, q[0].waddr});
                check_eq("wr_data", mem_wdata, q[0].wdata);
                check_eq("wr_type", {29'h0, mem_type}, 32'h2);
            end
            if (resp_valid) begin
                check_eq("rdata", resp_rdata, q[0].rdata);
                check_eq("misaligned", {31'h0, resp_misaligned}, {31'h0, q[0].mis});
                check_eq("latency", cyc + 1 - q[0].acc, q[0].lat);
                check_eq("write_count", cur_wr, q[0].nwr);
                cur_wr = 0;
                void'(q.pop_front());
            end
        end
    end

    // Predict the response and update the model memory; called at a negedge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        exp_t          e;
        int            n;
        logic [31:0]   w;
        logic [AW-1:0] wa;
        logic [1:0]    b;
        logic [7:0]    by;
        logic [15:0]   hw;
        logic          flt;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check_eq("ready_timeout", {31'h0, req_ready}, 32'h1);
            return;
        end
        wa = addr[AW+1:2];
        b  = addr[1:0];
        w  = mm[wa];
        if (st) flt = !(f3 == 3'b000 || (f3 == 3'b001 && !b[0]) || (f3 == 3'b010 && b == 2'b00));
        else flt = !(f3 == 3'b000 || f3 == 3'b100 || ((f3 == 3'b001 || f3 == 3'b101) && !b[0])
                     || (f3 == 3'b010 && b == 2'b00));
        e.rdata = 32'h0; e.mis = flt; e.lat = 1; e.acc = cyc + 1; e.nwr = 0;
        e.waddr = wa; e.wdata = 32'h0;
        if (!flt) begin
            by = 8'(w >> (8 * b));
            hw = 16'(w >> (16 * b[1]));
            if (st) begin
                e.wdata = w;
                case (f3)
                    3'b000:  begin e.wdata[8*b +: 8] = wd[7:0]; e.lat = 3; end
                    3'b001:  begin e.wdata[16*b[1] +: 16] = wd[15:0]; e.lat = 3; end
                    default: begin e.wdata = wd; e.lat = 2; end
                endcase
                e.nwr = 1;
                mm[wa] = e.wdata;
            end else begin
                e.lat = 2;
                case (f3)
                    3'b000:  e.rdata = {{24{by[7]}}, by};
                    3'b100:  e.rdata = {24'h0, by};
                    3'b001:  e.rdata = {{16{hw[15]}}, hw};
                    3'b101:  e.rdata = {16'h0, hw};
                    default: e.rdata = w;
                endcase
            end
        end
        q.push_back(e);
        req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        check_eq({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
        check_eq({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        check_eq({tag, "_resp_mis"}, {31'h0, resp_misaligned}, 32'h0);
        check_eq({tag, "_mem_we"}, {31'h0, mem_is_store}, 32'h0);
        check_eq({tag, "_mem_addr"}, {18'h0, mem_addr}, 32'h0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check_eq({tag, "_mem_type"}, {29'h0, mem_type}, 32'h2);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mm[i] = 32'h0;
        #2 rst = 1'b1;
        #1 check_reset_values("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b1, 3'b010, 32'h0000_0400, 32'hDEAD_BEEF);  // SW
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);          // LW
        issue(1'b0, 3'b000, 32'h0000_0403, 32'h0);          // LB
        issue(1'b0, 3'b100, 32'h0000_0403, 32'h0);          // LBU
        issue(1'b0, 3'b001, 32'h0000_0402, 32'h0);          // LH
        issue(1'b0, 3'b101, 32'h0000_0400, 32'h0);          // LHU
        issue(1'b1, 3'b000, 32'h0000_0401, 32'h1234_5655);  // SB
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        issue(1'b1, 3'b001, 32'h0000_0401, 32'h1111_2222);  // SH misaligned
        issue(1'b0, 3'b010, 32'h0000_0402, 32'h0);          // LW misaligned
        issue(1'b1, 3'b010, 32'h0000_0000, 32'hA5A5_A5A5);
        issue(1'b0, 3'b010, 32'h0000_0000, 32'h0);
        issue(1'b0, 3'b010, 32'hFFFF_0400, 32'h0);          // wraps onto word 0x100
        issue(1'b1, 3'b001, 32'h0000_0402, 32'h1234_CAFE);  // SH upper lane
        issue(1'b0, 3'b000, 32'h0000_0000, 32'h0);
        issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);          // undefined load
        issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);          // undefined store
        issue(1'b0, 3'b110, 32'h0000_0000, 32'h0);
        issue(1'b1, 3'b000, 32'h0000_0003, 32'h0000_0077);  // SB top byte
        issue(1'b0, 3'b001, 32'h0000_0002, 32'h0);

        // SB aborted by reset during its READ cycle: no write, no response.
        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_eq("pre_abort_drain", q.size(), 32'h0);
            while (!req_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0000_0401;
        req_wdata = 32'h0000_0099; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);

        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("drain", q.size(), 32'h0);
        check_eq("mem_word_100", mem[14'h100], mm[14'h100]);
        check_eq("mem_word_000", mem[14'h000], mm[14'h000]);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
